// File: rtl/phase_shift_slew.sv
// NCO phase accumulator that spreads a signed phase shift evenly over N clocks.
// Optional macro PHASE_SLEW_RESTART_EN: an apply while busy restarts with the new operands.
module phase_shift_slew (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] freq,
    input  logic        apply,
    input  logic [31:0] phase_shift,
    input  logic [31:0] slew_cycles,
    output logic [31:0] phase,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, APPLY0, DIV, SLEW} state_t;

    state_t      state, state_next;
    logic        load, finish;
    logic        sign;
    logic [31:0] shift_raw, divisor, quo, rem, k;
    logic [4:0]  bit_cnt;
    logic [31:0] magnitude, corr, corr_mag;
    logic [32:0] rem_shift, trial;

    // Two's-complement negate also yields 2^31 for 0x8000_0000 when read as unsigned.
    assign magnitude = phase_shift[31] ? (~phase_shift + 32'd1) : phase_shift;

    assign rem_shift = {rem, quo[31]};
    assign trial     = rem_shift - {1'b0, divisor};

    always_comb begin
        state_next = state;
        load       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE:   load = apply;
            APPLY0: begin
                finish     = 1'b1;
                state_next = IDLE;
            end
            DIV:    if (bit_cnt == 5'd31) state_next = SLEW;
            SLEW:   if (k == divisor - 32'd1) begin
                finish     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
`ifdef PHASE_SLEW_RESTART_EN
        if (state != IDLE && apply) begin
            load   = 1'b1;
            finish = 1'b0;
        end
`endif
        if (load) state_next = (slew_cycles == 32'd0) ? APPLY0 : DIV;
    end

    // Remainder is spread one extra unit per clock over the first r slew clocks.
    always_comb begin
        corr     = 32'd0;
        corr_mag = quo + {31'd0, (k < rem)};
        case (state)
            APPLY0:  corr = shift_raw;
            SLEW:    corr = sign ? (~corr_mag + 32'd1) : corr_mag;
            default: corr = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            phase     <= 32'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sign      <= 1'b0;
            shift_raw <= 32'd0;
            divisor   <= 32'd0;
            quo       <= 32'd0;
            rem       <= 32'd0;
            k         <= 32'd0;
            bit_cnt   <= 5'd0;
        end else begin
            state <= state_next;
            phase <= phase + freq + corr;
            done  <= finish;
            if (finish) busy <= 1'b0;
            if (load) begin
                busy      <= 1'b1;
                sign      <= phase_shift[31];
                shift_raw <= phase_shift;
                divisor   <= slew_cycles;
                quo       <= magnitude;
                rem       <= 32'd0;
                k         <= 32'd0;
                bit_cnt   <= 5'd0;
            end else begin
                case (state)
                    DIV: begin
                        bit_cnt <= bit_cnt + 5'd1;
                        k       <= 32'd0;
                        if (!trial[32]) begin
                            rem <= trial[31:0];
                            quo <= {quo[30:0], 1'b1};
                        end else begin
                            rem <= rem_shift[31:0];
                            quo <= {quo[30:0], 1'b0};
                        end
                    end
                    SLEW:    k <= k + 32'd1;
                    default: ;
                endcase
            end
        end
    end

endmodule
